// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - byte-addressed data memory controller with clear, load extension and fault hold
module dm_ctrl #(
  parameter int DEPTH          = 2048,
  parameter int ADDR_W         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              exc_ack,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              exc,
  output logic [1:0]        exc_code,
  output logic [ADDR_W-1:0] bad_addr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WORDS = DEPTH / 4;
  localparam int IW    = AW - 2;
  localparam logic [IW-1:0] LAST_WORD = IW'(WORDS - 1);

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_FAULT} state_t;

  state_t              r_state;
  logic                r_ready;
  logic                r_done;
  logic [31:0]         r_rdata;
  logic                r_exc;
  logic [1:0]          r_exc_code;
  logic [ADDR_W-1:0]   r_bad_addr;
  logic [IW-1:0]       r_clr_idx;
  logic [31:0]         r_mem [WORDS];

  logic [IW-1:0]       w_idx;
  logic                w_oor;
  logic                w_misaligned;
  logic [1:0]          w_code;
  logic                w_accept;
  logic                w_store;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [3:0]          w_be;
  logic [31:0]         w_wlane;

  assign w_idx        = addr[AW-1:2];
  assign w_oor        = ({1'b0, addr} >= (ADDR_W + 1)'(DEPTH)) || (size == 2'b10);
  assign w_misaligned = ((size == 2'b01) && addr[0]) || ((size == 2'b11) && (addr[1:0] != 2'b00));
  assign w_accept     = req & r_ready;
  assign w_store      = w_accept & we & (w_code == 2'b00);

  // Range/illegal size outranks misalignment.
  always_comb begin
    w_code = 2'b00;
    if (w_oor)             w_code = 2'b11;
    else if (w_misaligned) w_code = we ? 2'b10 : 2'b01;
  end

  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = w_word[7:0];
    case (addr[1:0])
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
    w_half = addr[1] ? w_word[31:16] : w_word[15:0];
    case (size)
      2'b00:   w_load = {{24{sign_ext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{sign_ext & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    w_be    = 4'b1111;
    w_wlane = wdata;
    case (size)
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && (r_state == S_CLEAR)) begin
      r_mem[r_clr_idx] <= '0;
    end else if (rst_n && w_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      r_ready    <= !CLEAR_ON_RESET;
      r_clr_idx  <= '0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_exc      <= 1'b0;
      r_exc_code <= 2'b00;
      r_bad_addr <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == LAST_WORD) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_done <= 1'b1;
            if (w_code != 2'b00) begin
              r_exc      <= 1'b1;
              r_exc_code <= w_code;
              r_bad_addr <= addr;
              r_ready    <= 1'b0;
              r_state    <= S_FAULT;
            end else if (!we) begin
              r_rdata <= w_load;
            end
          end
        end
        S_FAULT: begin
          if (exc_ack) begin
            r_exc   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign exc      = r_exc;
  assign exc_code = r_exc_code;
  assign bad_addr = r_bad_addr;

endmodule
